serial_alu_seq: RTL and testbench
=================================

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port mode  input  3  operation code, passed unchanged to the 1-bit ALU slice M input.
REQ-006 SHALL have ports op_a, op_b  input  WIDTH  operands.
REQ-007 SHALL have port cin  input  1  initial carry into bit 0.
REQ-008 SHALL have ports alu_m (output 3), alu_a, alu_b, alu_c (output 1) driving the 1-bit ALU slice M, a, b, c inputs.
REQ-009 SHALL have ports alu_out, alu_next  input  1  slice result bit and carry-out.
REQ-010 SHALL have ports busy, done, cout  output  1  and result  output  WIDTH.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-012 In IDLE or DONE with start=1: SHALL latch op_a, op_b, mode, load carry flop with cin, clear bit counter, clear result, enter SHIFT.
REQ-013 In SHIFT: SHALL drive alu_a=a_sh[0], alu_b=b_sh[0], alu_c=carry flop, alu_m=latched mode (combinational from registers).
REQ-014 Each SHIFT cycle: SHALL shift alu_out into result MSB (result shifts right), shift a_sh/b_sh right by 1, load carry flop from alu_next, increment counter.
REQ-015 After exactly WIDTH SHIFT cycles: SHALL enter DONE; result[i] equals the slice output for bit i.
REQ-016 done SHALL be 1 only in DONE (one cycle unless restarted); busy SHALL be 1 only in SHIFT.
REQ-017 cout SHALL equal carry flop (final alu_next) and is valid from DONE until next accepted start.
REQ-018 Latency: start sampled at edge N -> done high in cycle following edge N+WIDTH.
REQ-019 result and cout SHALL hold after DONE until next accepted start.
REQ-020 start while busy SHALL be ignored; latched operands and count unaffected.
REQ-021 start in DONE SHALL be accepted (back-to-back, no idle cycle); done still pulses that cycle.
REQ-022 DONE without start SHALL return to IDLE.
REQ-023 In IDLE/DONE alu_a, alu_b, alu_c SHALL be 0 and alu_m the latched mode.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, result=0, cout=0, busy=0, done=0, carry flop=0, counter=0, shift registers=0, latched mode=000.
REQ-025 rst mid-operation SHALL abort it; no done pulse is produced for the aborted operation.

Configuration
REQ-026 Macro SERIAL_ALU_ZERO_FLAG_EN defined: SHALL add output zero (1 bit), sticky-OR of shifted result bits, zero=1 in DONE/hold when all WIDTH result bits are 0; reset value 0, cleared on accepted start.
REQ-027 Macro undefined: SHALL have no zero port and no associated logic.

Verification (WIDTH=8, slice attached, mode=000 add)
REQ-028 op_a=8'h35, op_b=8'h4A, cin=0, start pulse -> busy 8 cycles, done in 9th cycle, result=8'h7F, cout=0.
REQ-029 op_a=8'hFF, op_b=8'h01, cin=0 -> result=8'h00, cout=1, zero=1 (macro defined).
REQ-030 op_a=8'h10, op_b=8'h20, cin=1 -> result=8'h31, cout=0, zero=0.
REQ-031 start re-pulsed with op_a=8'h00 during SHIFT of 8'h35+8'h4A -> ignored, result=8'h7F.
REQ-032 rst pulsed at SHIFT cycle 4 -> busy=0, result=0 at once; no done; next start runs normally.
REQ-033 start held high through DONE with new operands 8'h01+8'h01 -> done pulse, then immediate SHIFT, result=8'h02 after 8 more cycles.

Source files
------------

// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: operand/result handshake and 1-bit ALU slice hookup for serial_alu_seq
// Optional zero flag present when SERIAL_ALU_ZERO_FLAG_EN is defined.
interface serial_alu_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic [2:0] mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic cin;
  logic [2:0] alu_m;
  logic alu_a;
  logic alu_b;
  logic alu_c;
  logic alu_out;
  logic alu_next;
  logic busy;
  logic done;
  logic cout;
  logic [WIDTH-1:0] result;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic zero;
`endif
  modport slave (
    input start, mode, op_a, op_b, cin, alu_out, alu_next,
    output alu_m, alu_a, alu_b, alu_c, busy, done, cout, result
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    , output zero
`endif
  );
  modport master (
    output start, mode, op_a, op_b, cin, alu_out, alu_next,
    input alu_m, alu_a, alu_b, alu_c, busy, done, cout, result
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    , input zero
`endif
  );
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer driving an external 1-bit ALU slice, LSB first
// Define SERIAL_ALU_ZERO_FLAG_EN to add the sticky zero flag output.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] cnt;
  logic [2:0] mode_q;
  logic carry;
  logic accept, last;
  assign accept = bus.start && state != SHIFT;
  assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == SHIFT ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
  end
  always_comb begin
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
    bus.alu_a = state == SHIFT ? a_sh[0] : 1'b0;
    bus.alu_b = state == SHIFT ? b_sh[0] : 1'b0;
    bus.alu_c = state == SHIFT ? carry : 1'b0;
    bus.alu_m = mode_q;
    bus.cout = carry;
    bus.result = res;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      mode_q <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.op_a;
      b_sh <= bus.op_b;
      res <= '0;
      cnt <= '0;
      mode_q <= bus.mode;
      carry <= bus.cin;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res <= {bus.alu_out, res[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      carry <= bus.alu_next;
    end
  end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic seen_one, zero_q;
  // zero is resolved on the last shift so it is stable for the whole hold period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_one <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      seen_one <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == SHIFT) begin
      seen_one <= seen_one | bus.alu_out;
      zero_q <= last ? ~(seen_one | bus.alu_out) : zero_q;
    end
  end
  assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: scoreboard bench for serial_alu_seq with a behavioural 1-bit ALU slice attached
module tb_serial_alu_seq;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] r;
    logic c;
    logic z;
    int cyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t last_e;
  serial_alu_seq_if #(.WIDTH(W)) bus ();
  serial_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slice: 000 add, 001 and, 010 or, 011 xor (logic ops pass carry through)
  always_comb begin
    case (bus.alu_m)
      3'd1: begin bus.alu_out = bus.alu_a & bus.alu_b; bus.alu_next = bus.alu_c; end
      3'd2: begin bus.alu_out = bus.alu_a | bus.alu_b; bus.alu_next = bus.alu_c; end
      3'd3: begin bus.alu_out = bus.alu_a ^ bus.alu_b; bus.alu_next = bus.alu_c; end
      default: begin
        bus.alu_out = bus.alu_a ^ bus.alu_b ^ bus.alu_c;
        bus.alu_next = (bus.alu_a & bus.alu_b) | (bus.alu_c & (bus.alu_a ^ bus.alu_b));
      end
    endcase
  end
  function automatic exp_t model(logic [2:0] m, logic [W-1:0] a, logic [W-1:0] b, logic c);
    exp_t e;
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    case (m)
      3'd1: {e.c, e.r} = {c, a & b};
      3'd2: {e.c, e.r} = {c, a | b};
      3'd3: {e.c, e.r} = {c, a ^ b};
      default: {e.c, e.r} = s;
    endcase
    e.z = e.r == '0;
    e.cyc = 0;
    return e;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic start_op(logic [2:0] m, logic [W-1:0] a, logic [W-1:0] b, logic c);
    bus.mode = m;
    bus.op_a = a;
    bus.op_b = b;
    bus.cin = c;
    bus.start = 1;
    @(posedge clk);
    #1;
    last_e = model(m, a, b, c);
    last_e.cyc = cyc + W;
    q.push_back(last_e);
    bus.start = 0;
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < W + 4 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask
  task automatic hold_chk();
    repeat (2) @(posedge clk);
    #1;
    chk("hold_result", 64'(bus.result), 64'(last_e.r));
    chk("hold_cout", 64'(bus.cout), 64'(last_e.c));
    chk("hold_done_low", 64'(bus.done), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 64'(bus.result), 64'(e.r));
        chk("cout", 64'(bus.cout), 64'(e.c));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("busy_in_done", 64'(bus.busy), 64'd0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        chk("zero", 64'(bus.zero), 64'(e.z));
`endif
      end
    end
  end
  initial begin
    bus.start = 0;
    bus.mode = 0;
    bus.op_a = 0;
    bus.op_b = 0;
    bus.cin = 0;
    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_alu", 64'({bus.alu_m, bus.alu_a, bus.alu_b, bus.alu_c}), 64'd0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    chk("rst_zero", 64'(bus.zero), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 0;
    start_op(3'd0, 8'h35, 8'h4A, 1'b0);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    wait_done();
    hold_chk();
    start_op(3'd0, 8'hFF, 8'h01, 1'b0);
    wait_done();
    hold_chk();
    start_op(3'd0, 8'h10, 8'h20, 1'b1);
    wait_done();
    hold_chk();
    start_op(3'd0, 8'h35, 8'h4A, 1'b0);
    @(posedge clk);
    #1;
    bus.op_a = 8'h00;
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    wait_done();
    hold_chk();
    start_op(3'd0, 8'h35, 8'h4A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (12) @(posedge clk);
    #1;
    start_op(3'd0, 8'h12, 8'h34, 1'b0);
    wait_done();
    hold_chk();
    start_op(3'd0, 8'h35, 8'h4A, 1'b0);
    bus.op_a = 8'h01;
    bus.op_b = 8'h01;
    bus.start = 1;
    wait_done();
    @(posedge clk);
    #1;
    last_e = model(3'd0, 8'h01, 8'h01, 1'b0);
    last_e.cyc = cyc + W;
    q.push_back(last_e);
    bus.start = 0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done();
    hold_chk();
    for (int i = 0; i < 30; i++) begin
      start_op(3'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, W - 3)) @(posedge clk);
        #1;
        bus.mode = 3'($urandom_range(0, 3));
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
        bus.cin = 1'($urandom);
        bus.start = 1;
        @(posedge clk);
        #1;
        bus.start = 0;
      end
      wait_done();
      if ($urandom_range(0, 2) == 0) hold_chk();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
